// File: rtl/window_3x3_generator.sv
// window_3x3_generator: raster RGB444 stream to packed 3x3 windows for every interior pixel
//   in : clk, reset (async, high), pixel_in[11:0], pixel_valid, sof (qualified by pixel_valid)
//   out: color_data[107:0], window_valid, center_x, center_y, frame_done (all registered)
module window_3x3_generator #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_BITS   = 10,
  parameter int ROW_BITS   = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [11:0]         pixel_in,
  input  logic                pixel_valid,
  input  logic                sof,
  output logic [107:0]        color_data,
  output logic                window_valid,
  output logic [COL_BITS-1:0] center_x,
  output logic [ROW_BITS-1:0] center_y,
  output logic                frame_done
);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);
  logic [11:0] lb1_q [IMG_WIDTH];
  logic [11:0] lb2_q [IMG_WIDTH];
  logic [COL_BITS-1:0] col_q, col_d, pc, center_x_q, center_x_d;
  logic [ROW_BITS-1:0] row_q, row_d, pr, center_y_q, center_y_d;
  logic [11:0] mt_q, mm_q, mb_q, rt_q, rm_q, rb_q;
  logic [11:0] mt_d, mm_d, mb_d, rt_d, rm_d, rb_d;
  logic [11:0] lb1_rd, lb2_rd;
  logic [107:0] color_data_q, color_data_d;
  logic window_valid_q, window_valid_d, frame_done_q, frame_done_d;
  logic last_col, last_row;
  // Only the middle and right window columns are stored; the left column of the
  // outgoing window is the old middle column, so it never needs its own register.
  always_comb begin
    pc = sof ? '0 : col_q;
    pr = sof ? '0 : row_q;
    lb1_rd = lb1_q[pc];
    lb2_rd = lb2_q[pc];
    last_col = pc == COL_LAST;
    last_row = pr == ROW_LAST;
    col_d = !pixel_valid ? col_q : last_col ? '0 : pc + COL_BITS'(1);
    row_d = !pixel_valid ? row_q : !last_col ? pr : last_row ? '0 : pr + ROW_BITS'(1);
    mt_d = pixel_valid ? rt_q : mt_q;
    mm_d = pixel_valid ? rm_q : mm_q;
    mb_d = pixel_valid ? rb_q : mb_q;
    rt_d = pixel_valid ? lb2_rd : rt_q;
    rm_d = pixel_valid ? lb1_rd : rm_q;
    rb_d = pixel_valid ? pixel_in : rb_q;
    color_data_d = pixel_valid ? {rm_q, mm_q, lb1_rd, rt_q, rb_q, mt_q, lb2_rd, mb_q, pixel_in}
                               : color_data_q;
    window_valid_d = pixel_valid && pc >= COL_BITS'(2) && pr >= ROW_BITS'(2);
    frame_done_d = pixel_valid && last_col && last_row;
    center_x_d = pixel_valid ? pc - COL_BITS'(1) : center_x_q;
    center_y_d = pixel_valid ? pr - ROW_BITS'(1) : center_y_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      {mt_q, mm_q, mb_q, rt_q, rm_q, rb_q} <= '0;
      color_data_q <= '0;
      window_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      center_x_q <= '0;
      center_y_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      {mt_q, mm_q, mb_q, rt_q, rm_q, rb_q} <= {mt_d, mm_d, mb_d, rt_d, rm_d, rb_d};
      color_data_q <= color_data_d;
      window_valid_q <= window_valid_d;
      frame_done_q <= frame_done_d;
      center_x_q <= center_x_d;
      center_y_q <= center_y_d;
    end
  end
  // Line buffers are plain RAM: never reset, reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb2_q[pc] <= lb1_q[pc];
      lb1_q[pc] <= pixel_in;
    end
  end
  assign color_data = color_data_q;
  assign window_valid = window_valid_q;
  assign center_x = center_x_q;
  assign center_y = center_y_q;
  assign frame_done = frame_done_q;
endmodule
